// File: rtl/j1_io_hub.sv
// I/O hub for the j1 core bus: GPIO ports with edge capture and toggle writes,
// a prescaled tick timer with overflow interrupt, and a UART RX FIFO.
module j1_io_hub #(
   parameter int NPORTS     = 3,
   parameter int W          = 16,
   parameter int RXDEPTH    = 8,
   parameter int PRESCALE_W = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                io_rd,
   input  logic                io_wr,
   input  logic [15:0]         io_addr,
   input  logic [W-1:0]        io_dout,
   output logic [W-1:0]        io_din,
   output logic                interrupt,
   input  logic [NPORTS*W-1:0] port_in,
   output logic [NPORTS*W-1:0] port_out,
   output logic [NPORTS*W-1:0] port_dir,
   output logic                uart0_wr,
   output logic [7:0]          uart_w,
   input  logic                uart0_busy,
   input  logic                uart0_valid,
   input  logic [7:0]          uart0_data,
   output logic                uart0_rd
);

   localparam int AW = $clog2(RXDEPTH);
   localparam int CW = AW + 1;

   logic [NPORTS-1:0][W-1:0] pin_v;
   logic [NPORTS-1:0][W-1:0] out_q, out_d;
   logic [NPORTS-1:0][W-1:0] dir_q, dir_d;
   logic [NPORTS-1:0][W-1:0] edge_q, edge_d;
   logic [NPORTS-1:0][W-1:0] prev_q, prev_d;

   logic [7:0]            fifo_mem [RXDEPTH];
   logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  ack_q, ack_d;
   logic                  ovf_q, ovf_d;
   logic                  pending_q, pending_d;
   logic                  irq_q, irq_d;
   logic [W-1:0]          ticks_q, ticks_d;
   logic [PRESCALE_W-1:0] presc_q, presc_d;
   logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;

   logic       full, empty, push, pop, stat_rd, ovf_set;
   logic       tick, ticks_wr, presc_wr, ovf_evt;
   logic [7:0] head;
   logic [W-1:0] port_rd [NPORTS];

   assign pin_v    = port_in;
   assign port_out = out_q;
   assign port_dir = dir_q;
   assign uart0_wr = io_wr & io_addr[12];
   assign uart_w   = io_dout[7:0];
   assign interrupt = irq_q;

   // GPIO: toggle beats plain write; a fresh edge beats the read-clear
   always_comb begin
      out_d  = out_q;
      dir_d  = dir_q;
      edge_d = edge_q;
      prev_d = pin_v;
      for (int k = 0; k < NPORTS; k++) begin
         if (io_wr && io_addr[4*k+3])
            out_d[k] = out_q[k] ^ io_dout;
         else if (io_wr && io_addr[4*k+1])
            out_d[k] = io_dout;
         if (io_wr && io_addr[4*k+2])
            dir_d[k] = io_dout;
         if (io_rd && io_addr[4*k+3])
            edge_d[k] = '0;
         edge_d[k] = edge_d[k] | (pin_v[k] & ~prev_q[k]);
      end
   end

   for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
      assign port_rd[gi] = ({W{io_addr[4*gi]}}   & pin_v[gi])
                         | ({W{io_addr[4*gi+1]}} & out_q[gi])
                         | ({W{io_addr[4*gi+2]}} & dir_q[gi])
                         | ({W{io_addr[4*gi+3]}} & edge_q[gi]);
   end

   assign full  = (count_q == CW'(RXDEPTH));
   assign empty = (count_q == '0);
   assign head  = empty ? 8'h00 : fifo_mem[rptr_q];
   // ack_q masks the valid the UART still shows in the cycle after an ack
   assign uart0_rd = uart0_valid & ~full & ~ack_q & ~reset;
   assign push     = uart0_rd;
   assign pop      = io_rd & io_addr[12] & ~empty;
   assign stat_rd  = io_rd & io_addr[13];
   assign ovf_set  = uart0_valid & full & ~ack_q;

   assign tick     = (pcnt_q == presc_q);
   assign ticks_wr = io_wr & io_addr[14];
   assign presc_wr = io_wr & io_addr[15];
   assign ovf_evt  = tick & (&ticks_q) & ~ticks_wr;

   always_comb begin
      wptr_d    = push ? wptr_q + AW'(1) : wptr_q;
      rptr_d    = pop ? rptr_q + AW'(1) : rptr_q;
      count_d   = count_q + CW'(push) - CW'(pop);
      ack_d     = push;
      ovf_d     = ovf_set | (ovf_q & ~stat_rd);
      pending_d = ovf_evt | (pending_q & ~stat_rd);
      irq_d     = ovf_evt;
      presc_d   = presc_wr ? io_dout[PRESCALE_W-1:0] : presc_q;
      pcnt_d    = (ticks_wr || tick) ? '0 : pcnt_q + PRESCALE_W'(1);
      if (ticks_wr)
         ticks_d = io_dout;
      else if (tick)
         ticks_d = ticks_q + W'(1);
      else
         ticks_d = ticks_q;
   end

   always_comb begin
      io_din = '0;
      for (int k = 0; k < NPORTS; k++)
         io_din = io_din | port_rd[k];
      if (io_addr[12]) io_din = io_din | W'(head);
      if (io_addr[13]) io_din = io_din | W'({ovf_q, pending_q, ~empty, ~uart0_busy});
      if (io_addr[14]) io_din = io_din | ticks_q;
      if (io_addr[15]) io_din = io_din | W'(presc_q);
   end

   always_ff @(posedge clk) begin
      if (push && !reset)
         fifo_mem[wptr_q] <= uart0_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q     <= '0;
         dir_q     <= '0;
         edge_q    <= '0;
         prev_q    <= pin_v;
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         ack_q     <= 1'b0;
         ovf_q     <= 1'b0;
         pending_q <= 1'b0;
         irq_q     <= 1'b0;
         ticks_q   <= '0;
         presc_q   <= '0;
         pcnt_q    <= '0;
      end else begin
         out_q     <= out_d;
         dir_q     <= dir_d;
         edge_q    <= edge_d;
         prev_q    <= prev_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         ack_q     <= ack_d;
         ovf_q     <= ovf_d;
         pending_q <= pending_d;
         irq_q     <= irq_d;
         ticks_q   <= ticks_d;
         presc_q   <= presc_d;
         pcnt_q    <= pcnt_d;
      end
   end

endmodule

// File: tb/tb_j1_io_hub.sv
// Directed-plus-random bench for j1_io_hub against a queue/arithmetic reference model.
module tb_j1_io_hub;
   localparam int NP = 3;
   localparam int D  = 8;

   logic        clk = 1'b0, reset = 1'b1, io_rd = 1'b0, io_wr = 1'b0;
   logic [15:0] io_addr = '0, io_dout = '0;
   logic [15:0] io_din;
   logic        interrupt;
   logic [47:0] port_in = '0;
   logic [47:0] port_out, port_dir;
   logic        uart0_wr;
   logic [7:0]  uart_w;
   logic        uart0_busy = 1'b0, uart0_valid = 1'b0;
   logic [7:0]  uart0_data = '0;
   logic        uart0_rd;

   j1_io_hub #(.NPORTS(NP), .W(16), .RXDEPTH(D), .PRESCALE_W(8)) dut (
      .clk(clk), .reset(reset), .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr),
      .io_dout(io_dout), .io_din(io_din), .interrupt(interrupt), .port_in(port_in),
      .port_out(port_out), .port_dir(port_dir), .uart0_wr(uart0_wr), .uart_w(uart_w),
      .uart0_busy(uart0_busy), .uart0_valid(uart0_valid), .uart0_data(uart0_data),
      .uart0_rd(uart0_rd)
   );

   always #5 clk = ~clk;

   int tests_run = 0, tests_failed = 0;
   logic [15:0] out_m [NP], dir_m [NP], pin_m [NP], edge_m [NP];
   logic [7:0]  q [$];
   logic        ovf_m = 1'b0, pend_m = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] status_m();
      return {12'h000, ovf_m, pend_m, (q.size() != 0), ~uart0_busy};
   endfunction

   task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
      @(negedge clk); io_addr = a; io_rd = 1'b1;
      #1 d = io_din;
      @(posedge clk); #1 io_rd = 1'b0; io_addr = '0;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [15:0] v);
      @(negedge clk); io_addr = a; io_dout = v; io_wr = 1'b1;
      @(posedge clk); #1 io_wr = 1'b0; io_addr = '0;
   endtask

   task automatic rd_check(input string tag, input logic [15:0] a, input logic [15:0] e);
      logic [15:0] d;
      bus_read(a, d);
      check(tag, d, e);
   endtask

   task automatic set_pin(input int k, input logic [15:0] v);
      @(negedge clk); port_in[k*16 +: 16] = v;
      @(posedge clk); #1;
      edge_m[k] = edge_m[k] | (v & ~pin_m[k]);
      pin_m[k] = v;
   endtask

   task automatic push_byte(input logic [7:0] b, input string tag);
      logic acc;
      acc = (q.size() < D);
      @(negedge clk); uart0_valid = 1'b1; uart0_data = b;
      #1 check(tag, uart0_rd, acc);
      @(posedge clk); #1 uart0_valid = 1'b0;
      if (acc) q.push_back(b); else ovf_m = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic pop_check(input string tag);
      logic [15:0] e;
      e = (q.size() != 0) ? {8'h00, q[0]} : 16'h0000;
      rd_check(tag, 16'h1000, e);
      if (q.size() != 0) void'(q.pop_front());
   endtask

   task automatic status_check(input string tag);
      rd_check(tag, 16'h2000, status_m());
      ovf_m = 1'b0; pend_m = 1'b0;
   endtask

   task automatic timer_trial(input int p, input logic [15:0] start, input int ncyc, input string tag);
      int tn, tp;
      logic irq;
      bus_write(16'h8000, {8'($urandom), 8'(p)});
      rd_check({tag, "_presc"}, 16'h8000, 16'(p));
      bus_write(16'h4000, start);
      io_addr = 16'h4000;
      #1;
      for (int n = 0; n <= ncyc; n++) begin
         if (n > 0) begin @(posedge clk); #1; end
         tn = (int'(start) + n / (p + 1)) & 32'hFFFF;
         tp = (int'(start) + (n - 1) / (p + 1)) & 32'hFFFF;
         irq = (n > 0) && (tp == 32'hFFFF) && (tn != tp);
         check({tag, "_ticks"}, io_din, tn);
         check({tag, "_irq"}, interrupt, irq);
         if (irq) pend_m = 1'b1;
      end
      io_addr = '0;
      status_check({tag, "_pending"});
   endtask

   initial begin : main
      logic [15:0] a, b, c, v;
      for (int k = 0; k < NP; k++) begin
         out_m[k] = '0; dir_m[k] = '0; pin_m[k] = '0; edge_m[k] = '0;
      end

      // Reset state, observed combinationally while reset is held
      repeat (2) @(posedge clk);
      #1 io_addr = 16'h0002; #1 check("rst_out", io_din, 16'h0000);
      io_addr = 16'h0004; #1 check("rst_dir", io_din, 16'h0000);
      io_addr = 16'h4000; #1 check("rst_ticks", io_din, 16'h0000);
      io_addr = 16'h8000; #1 check("rst_presc", io_din, 16'h0000);
      io_addr = 16'h2000; #1 check("rst_status", io_din, status_m());
      check("rst_irq", interrupt, 1'b0);
      check("rst_pout", port_out, 48'h0);
      check("rst_pdir", port_dir, 48'h0);
      @(negedge clk); reset = 1'b0; io_addr = '0;

      // Write then toggle
      bus_write(16'h0002, 16'h00F0); out_m[0] = 16'h00F0;
      bus_write(16'h0008, 16'h0FF0); out_m[0] = out_m[0] ^ 16'h0FF0;
      rd_check("toggle_out", 16'h0002, out_m[0]);

      for (int k = 0; k < NP; k++) begin
         a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); v = 16'($urandom);
         bus_write(16'(1 << (4*k+1)), a); out_m[k] = a;
         bus_write(16'(1 << (4*k+3)), b); out_m[k] = out_m[k] ^ b;
         bus_write(16'((1 << (4*k+1)) | (1 << (4*k+3))), c); out_m[k] = out_m[k] ^ c;
         check("port_out", port_out[k*16 +: 16], out_m[k]);
         rd_check("out_rd", 16'(1 << (4*k+1)), out_m[k]);
         bus_write(16'(1 << (4*k+2)), a ^ c); dir_m[k] = a ^ c;
         check("port_dir", port_dir[k*16 +: 16], dir_m[k]);
         set_pin(k, v);
         rd_check("pin_rd", 16'(1 << (4*k)), pin_m[k]);
         rd_check("edge_rd", 16'(1 << (4*k+3)), edge_m[k]);
         edge_m[k] = '0;
      end
      rd_check("or_read", 16'h0006, out_m[0] | dir_m[0]);
      v = 16'($urandom);
      bus_write(16'h0222, v);
      for (int k = 0; k < NP; k++) out_m[k] = v;
      check("multi_wr", port_out, {out_m[2], out_m[1], out_m[0]});

      // Edge capture on port 0
      set_pin(0, 16'h0000);
      rd_check("edge_pre", 16'h0008, edge_m[0]); edge_m[0] = '0;
      set_pin(0, 16'h0001);
      rd_check("edge_rise", 16'h0008, edge_m[0]); edge_m[0] = '0;
      rd_check("edge_clr", 16'h0008, edge_m[0]);
      @(negedge clk); port_in[15:0] = 16'h0003; io_addr = 16'h0008; io_rd = 1'b1;
      #1 check("edge_same_rd", io_din, edge_m[0]);
      @(posedge clk); #1 io_rd = 1'b0; io_addr = '0;
      edge_m[0] = 16'h0003 & ~pin_m[0]; pin_m[0] = 16'h0003;
      rd_check("edge_set_wins", 16'h0008, edge_m[0]); edge_m[0] = '0;

      // FIFO fill, overflow, drain
      for (int i = 0; i < D; i++) push_byte(8'(8'h41 + i), "fill_ack");
      status_check("full_status");
      @(negedge clk); uart0_valid = 1'b1; uart0_data = 8'h49;
      #1 check("full_noack", uart0_rd, (q.size() < D));
      repeat (2) @(posedge clk);
      #1 uart0_valid = 1'b0; ovf_m = 1'b1;
      @(posedge clk); #1;
      status_check("ovf_status");
      for (int i = 0; i <= D; i++) pop_check("drain");

      // Simultaneous push and pop at one entry
      push_byte(8'($urandom), "one_push");
      v = 16'($urandom_range(0, 255));
      @(negedge clk); io_addr = 16'h1000; io_rd = 1'b1; uart0_valid = 1'b1; uart0_data = v[7:0];
      #1 check("sim_head", io_din, {8'h00, q[0]});
      check("sim_ack", uart0_rd, (q.size() < D));
      @(posedge clk); #1 io_rd = 1'b0; io_addr = '0; uart0_valid = 1'b0;
      void'(q.pop_front()); q.push_back(v[7:0]);
      @(posedge clk); #1;
      status_check("sim_status");
      pop_check("sim_new");
      pop_check("sim_empty");

      // Random FIFO traffic
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0, 1: push_byte(8'($urandom), "rnd_push");
            2: pop_check("rnd_pop");
            default: status_check("rnd_status");
         endcase
      end
      while (q.size() != 0) pop_check("rnd_drain");
      status_check("rnd_final");

      // TX strobe and busy flag
      v = 16'($urandom);
      @(negedge clk); io_addr = 16'h1000; io_dout = v; io_wr = 1'b1;
      #1 check("tx_strobe", uart0_wr, 1'b1);
      check("tx_byte", uart_w, v[7:0]);
      @(posedge clk); #1 io_wr = 1'b0; io_addr = '0;
      #1 check("tx_idle", uart0_wr, 1'b0);
      uart0_busy = 1'b1;
      status_check("busy_status");
      uart0_busy = 1'b0;

      // Timer
      timer_trial(3, 16'hFFFE, 10, "tmr_dir");
      status_check("pending_cleared");
      for (int t = 0; t < 3; t++)
         timer_trial(int'($urandom_range(0, 3)), 16'(16'hFFFF - $urandom_range(0, 1)), 16, "tmr_rnd");

      // Tick write on a tick cycle
      bus_write(16'h8000, 16'h0000);
      bus_write(16'h4000, 16'h1234);
      io_addr = 16'h4000;
      #1 check("ticks_wr_wins", io_din, 16'h1234);
      @(posedge clk); #1 check("ticks_after_wr", io_din, 16'h1235);
      io_addr = '0;

      // Reset in the middle of a FIFO fill
      push_byte(8'($urandom), "pre_rst_push");
      push_byte(8'($urandom), "pre_rst_push");
      @(negedge clk); reset = 1'b1; uart0_valid = 1'b1; uart0_data = 8'hAA;
      #1 check("rst_no_ack", uart0_rd, 1'b0);
      @(posedge clk); #1 uart0_valid = 1'b0;
      @(negedge clk); reset = 1'b0;
      q.delete(); ovf_m = 1'b0; pend_m = 1'b0;
      for (int k = 0; k < NP; k++) begin out_m[k] = '0; dir_m[k] = '0; edge_m[k] = '0; end
      status_check("rst_mid_status");
      pop_check("rst_mid_pop");
      check("rst_mid_pout", port_out, {out_m[2], out_m[1], out_m[0]});
      rd_check("rst_mid_edge", 16'h0008, edge_m[0]);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
